// File: rtl/sseg_pkg.sv
// rtl/sseg_pkg.sv - shared seven-segment constants and types
package sseg_pkg;
    typedef logic [7:0] sseg_t;

    localparam sseg_t SSEG_BLANK = 8'hFF;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;
endpackage

// File: rtl/sseg_scan_timer.sv
// rtl/sseg_scan_timer.sv - dwell counter and digit index for the scan multiplexer
module sseg_scan_timer #(
    parameter int N_DIGITS = 4,
    parameter int DWELL_W  = 16,
    parameter int IDX_W    = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             reset,
    output logic [IDX_W-1:0] idx,
    output logic [3:0]       gate,
    output logic             frame_end
);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    logic [DWELL_W-1:0] dwell;
    logic               dwell_wrap;

    assign dwell_wrap = &dwell;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dwell <= '0;
            idx   <= '0;
        end else begin
            dwell <= dwell + 1'b1;
            if (dwell_wrap) begin
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            end
        end
    end

    // Top nibble of dwell is the brightness phase within a digit slot
    assign gate      = dwell[DWELL_W-1 -: 4];
    assign frame_end = dwell_wrap && (idx == LAST_IDX);
endmodule

// File: rtl/sseg_scan_mux.sv
// rtl/sseg_scan_mux.sv - double-buffered, brightness-gated seven-segment scan driver
module sseg_scan_mux
    import sseg_pkg::*;
#(
    parameter int N_DIGITS = 4,
    parameter int DWELL_W  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [8*N_DIGITS-1:0] in_sseg,
    input  logic                  load,
    input  logic                  enable,
    input  logic [3:0]            bright,
    output logic [N_DIGITS-1:0]   an,
    output logic [7:0]            sseg,
    output logic                  pending,
    output logic                  frame_done
);
    localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [N_DIGITS-1:0]   AN_ONE = N_DIGITS'(1);
    localparam logic [8*N_DIGITS-1:0] BLANK_BUF = {N_DIGITS{SSEG_BLANK}};

    logic [IDX_W-1:0]      idx;
    logic [3:0]            gate;
    logic                  frame_end;
    logic [8*N_DIGITS-1:0] pend_buf;
    logic [8*N_DIGITS-1:0] disp_buf;
    logic                  pend_flag;
    logic                  lit;

    sseg_scan_timer #(
        .N_DIGITS (N_DIGITS),
        .DWELL_W  (DWELL_W),
        .IDX_W    (IDX_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .idx       (idx),
        .gate      (gate),
        .frame_end (frame_end)
    );

    // A load in the boundary cycle bypasses pend_buf so it commits immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_buf  <= BLANK_BUF;
            disp_buf  <= BLANK_BUF;
            pend_flag <= 1'b0;
        end else begin
            if (load) begin
                pend_buf  <= in_sseg;
                pend_flag <= 1'b1;
            end
            if (frame_end && (pend_flag || load)) begin
                disp_buf  <= load ? in_sseg : pend_buf;
                pend_flag <= 1'b0;
            end
        end
    end

    assign lit = enable && (gate <= bright);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            an         <= '1;
            sseg       <= SSEG_BLANK;
            frame_done <= 1'b0;
        end else begin
            frame_done <= frame_end;
            if (lit) begin
                an   <= ~(AN_ONE << idx);
                sseg <= disp_buf[8*int'(idx) +: 8];
            end else begin
                an   <= '1;
                sseg <= SSEG_BLANK;
            end
        end
    end

    assign pending = pend_flag;
endmodule

// File: tb/tb_sseg_scan_mux.sv
// tb/tb_sseg_scan_mux.sv - scoreboard bench for sseg_scan_mux against a cycle-count reference model
module tb_sseg_scan_mux;
    localparam int ND    = 4;
    localparam int DW    = 4;
    localparam int SLOT  = 1 << DW;
    localparam int FRAME = ND * SLOT;

    logic            clk;
    logic            reset;
    logic [8*ND-1:0] in_sseg;
    logic            load;
    logic            enable;
    logic [3:0]      bright;
    logic [ND-1:0]   an;
    logic [7:0]      sseg;
    logic            pending;
    logic            frame_done;

    sseg_scan_mux #(.N_DIGITS(ND), .DWELL_W(DW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_sseg    (in_sseg),
        .load       (load),
        .enable     (enable),
        .bright     (bright),
        .an         (an),
        .sseg       (sseg),
        .pending    (pending),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [ND-1:0] an;
        logic [7:0]    sseg;
        logic          pending;
        logic          frame_done;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    // Reference model: position in the scan follows purely from cycles since reset
    int         k = 0;
    logic [7:0] m_disp[ND];
    logic [7:0] m_pend[ND];
    bit         m_flag;
    int         m_dw, m_ix;
    bit         m_lit, m_t;
    exp_t       e;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            k = 0;
            for (int j = 0; j < ND; j++) begin
                m_disp[j] = 8'hFF;
                m_pend[j] = 8'hFF;
            end
            m_flag = 0;
            sb.delete();
        end else begin
            m_dw  = k % SLOT;
            m_ix  = (k / SLOT) % ND;
            m_t   = (k % FRAME) == FRAME - 1;
            m_lit = enable && ((m_dw * 16) / SLOT) <= int'(bright);
            e.an         = m_lit ? ~(ND'(1) << m_ix) : '1;
            e.sseg       = m_lit ? m_disp[m_ix] : 8'hFF;
            e.frame_done = m_t;
            if (load) begin
                for (int j = 0; j < ND; j++) m_pend[j] = in_sseg[8*j +: 8];
                m_flag = 1;
            end
            if (m_t && m_flag) begin
                for (int j = 0; j < ND; j++) m_disp[j] = m_pend[j];
                m_flag = 0;
            end
            e.pending = m_flag;
            sb.push_back(e);
            k++;
        end
    end

    exp_t got;
    always @(negedge clk) begin
        if (reset) begin
            chk("reset_an", 32'(an), 32'(4'hF));
            chk("reset_sseg", 32'(sseg), 32'hFF);
        end else if (sb.size() > 0) begin
            got = sb.pop_front();
            chk("an", 32'(an), 32'(got.an));
            chk("sseg", 32'(sseg), 32'(got.sseg));
            chk("pending", 32'(pending), 32'(got.pending));
            chk("frame_done", 32'(frame_done), 32'(got.frame_done));
            chk("an_onehot", 32'($countones(~an) <= 1), 32'h1);
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_phase(input int ph);
        for (int n = 0; n < 2 * FRAME; n++) begin
            if (k % FRAME == ph) return;
            @(negedge clk);
        end
        n_fail++;
        $display("FAIL wait_phase timeout: got phase %0d expected %0d", k % FRAME, ph);
    endtask

    task automatic do_load(input logic [8*ND-1:0] v);
        in_sseg = v;
        load    = 1'b1;
        @(negedge clk);
        load    = 1'b0;
        in_sseg = $urandom();
    endtask

    initial begin
        reset   = 1'b1;
        load    = 1'b0;
        enable  = 1'b1;
        bright  = 4'd15;
        in_sseg = '0;
        cycles(3);
        reset = 1'b0;
        cycles(2 * FRAME);

        wait_phase(20);
        do_load(32'h8112_0301);
        cycles(FRAME + 40);

        wait_phase(10);
        do_load($urandom());
        wait_phase(40);
        do_load($urandom());
        cycles(FRAME + 20);

        wait_phase(FRAME - 1);
        do_load($urandom());
        cycles(FRAME + 10);

        bright = 4'd0;
        cycles(FRAME);
        bright = 4'd7;
        do_load($urandom());
        cycles(FRAME);
        bright = 4'd15;

        enable = 1'b0;
        cycles(100);
        enable = 1'b1;
        cycles(FRAME);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                in_sseg = $urandom();
                load    = 1'b1;
            end else begin
                load = 1'b0;
            end
            if ($urandom_range(0, 29) == 0) bright = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 49) == 0) enable = ~enable;
            @(negedge clk);
        end
        load   = 1'b0;
        enable = 1'b1;
        bright = 4'd15;
        cycles(FRAME);

        wait_phase(5);
        do_load($urandom());
        wait_phase(2 * SLOT + 4);
        chk("pre_reset_pending", 32'(pending), 32'h1);
        chk("pre_reset_an", 32'(an), 32'(4'b1011));
        #2 reset = 1'b1;
        #1;
        chk("async_reset_an", 32'(an), 32'(4'hF));
        chk("async_reset_sseg", 32'(sseg), 32'hFF);
        chk("async_reset_pending", 32'(pending), 32'h0);
        cycles(2);
        reset = 1'b0;
        cycles(2 * FRAME + 4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
